reg_wb_scheduler: RTL

Schedules the single write port of reg_file between two writeback sources and tracks pending register writes.
- Source A: the single-cycle ALU/writeback path.
- Source B: the long-latency load/multi-cycle unit.
- A per-register busy scoreboard stalls issue on RAW/WAW hazards against outstanding long-latency writes.
- Drives WE3/AD3/WD3 of reg_file directly. Sits between the decode/issue stage and the register file.

---
 rtl/reg_sched_pkg.sv | 19 +
 rtl/wb_arbiter.sv | 74 +++++++
 rtl/reg_wb_scheduler.sv | 96 +++++++++
 3 files changed

// File: rtl/reg_sched_pkg.sv
// Shared widths, limits and writeback request types for the register
// writeback scheduler.
package reg_sched_pkg;

  localparam int ADDR_W_DEF       = 5;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_CNT_W     = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter.sv
// Two-source arbiter for the single register-file write port: A wins by
// default, B wins once it has waited STARVE_LIMIT consecutive cycles.
module wb_arbiter
  import reg_sched_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH    = DATA_W_DEF,
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_data,
  output logic                     b_ready,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  // Grant selection and write-port mux; nothing is granted while in reset.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    we3     = 1'b0;
    ad3     = {ADDRESS_WIDTH{1'b0}};
    wd3     = {DATA_WIDTH{1'b0}};
    if (rst) begin
      a_ready = 1'b0;
    end else if (b_valid && ((starve_q == LIMIT) || !a_valid)) begin
      b_ready = 1'b1;
      ad3     = b_addr;
      wd3     = b_data;
      we3     = (b_addr != {ADDRESS_WIDTH{1'b0}});
    end else if (a_valid) begin
      a_ready = 1'b1;
      ad3     = a_addr;
      wd3     = a_data;
      we3     = (a_addr != {ADDRESS_WIDTH{1'b0}});
    end else begin
      we3 = 1'b0;
    end
  end

  // Starvation counter next state: counts cycles B waits, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!b_valid || b_ready) begin
      starve_d = {STARVE_CNT_W{1'b0}};
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= {STARVE_CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Register writeback scheduler: arbitrates the reg_file write port between
// the ALU path (A) and the long-latency unit (B) and stalls issue on hazards.
module reg_wb_scheduler
  import reg_sched_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH    = DATA_W_DEF,
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDRESS_WIDTH-1:0] issue_rs1,
  input  logic [ADDRESS_WIDTH-1:0] issue_rs2,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic                     issue_long,
  output logic                     stall,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_data,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;

  logic [NREG-1:0] busy_q, busy_d;
  logic            issue_fire_s;

  wb_arbiter #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .STARVE_LIMIT  (STARVE_LIMIT)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .b_ready (b_ready),
    .we3     (we3),
    .ad3     (ad3),
    .wd3     (wd3)
  );

  // Hazard check against registered busy bits only, so a bit cleared this
  // cycle still stalls until the next one.
  always_comb begin
    stall        = 1'b1;
    issue_fire_s = 1'b0;
    if (rst) begin
      stall = 1'b1;
    end else begin
      stall = issue_valid &
              (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
      issue_fire_s = issue_valid & ~stall & issue_long &
                     (issue_rd != {ADDRESS_WIDTH{1'b0}});
    end
  end

  // Scoreboard next state: set on long issue, clear on B writeback.
  always_comb begin
    busy_d = busy_q;
    if (issue_fire_s) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_q;
    end
    if (b_valid && b_ready) begin
      busy_d[b_addr] = 1'b0;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= {NREG{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule
